// File: rtl/mem_bus_arbiter_pkg.sv
// mem_bus_arbiter_pkg: shared encodings and constants for the memory bus arbiter
package mem_bus_arbiter_pkg;
    localparam int WORD_WIDTH = 32;
    localparam logic [WORD_WIDTH-1:0] ZERO_WORD = '0;
    localparam logic [31:0] BUS_ERR_DATA = 32'hDEAD_BEEF;
    localparam logic [3:0] BE_WORD = 4'hF;
    typedef enum logic [1:0] {MB_IDLE, MB_ST, MB_LD, MB_IF} mb_state_t;
endpackage

// File: rtl/mem_bus_arbiter_fetch_buffer.sv
// mem_bus_arbiter_fetch_buffer: one-entry instruction buffer tagged by fetch address
module mem_bus_arbiter_fetch_buffer
    import mem_bus_arbiter_pkg::*;
#(
    parameter int W = WORD_WIDTH
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] pc,
    input  logic         fill,
    input  logic [W-1:0] fill_tag,
    input  logic [W-1:0] fill_data,
    input  logic         inval,
    output logic         hit,
    output logic [W-1:0] data
);
    logic         valid;
    logic [W-1:0] tag;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid <= 1'b0;
            tag   <= '0;
            data  <= '0;
        end else if (fill) begin
            valid <= 1'b1;
            tag   <= fill_tag;
            data  <= fill_data;
        end else if (inval) begin
            valid <= 1'b0;
        end
    end
    assign hit = valid && (tag == pc);
endmodule

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: merges fetch, load and store ports onto one req/ack word bus
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int W       = WORD_WIDTH,
    parameter int TIMEOUT = 255
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] pc,
    output logic [W-1:0] read_inst,
    input  logic         load_en,
    input  logic [W-1:0] l_addr,
    output logic [W-1:0] l_data,
    input  logic         store_en,
    input  logic [W-1:0] s_addr,
    input  logic [W-1:0] s_data,
    input  logic [3:0]   s_be,
    output logic         if_stall,
    output logic         mem_stall,
    output logic         bus_req,
    output logic         bus_we,
    output logic [W-1:0] bus_addr,
    output logic [W-1:0] bus_wdata,
    output logic [3:0]   bus_be,
    input  logic         bus_ack,
    input  logic [W-1:0] bus_rdata,
    output logic         bus_err
);
    localparam int CW = $clog2(TIMEOUT + 1);
    mb_state_t    state;
    logic [CW-1:0] tmo_cnt;
    logic         load_done, store_done;
    logic [W-1:0] ld_addr_q, st_addr_q;
    logic         ld_hit, st_hit, fb_hit, tmo, finish;
    logic [W-1:0] rd;
    // a done flag only counts while the core still presents the same address
    assign ld_hit    = load_done && (l_addr == ld_addr_q);
    assign st_hit    = store_done && (s_addr == st_addr_q);
    assign tmo       = tmo_cnt == CW'(TIMEOUT - 1);
    assign finish    = state != MB_IDLE && (bus_ack || tmo);
    assign rd        = bus_ack ? bus_rdata : W'(BUS_ERR_DATA);
    assign mem_stall = (store_en && !st_hit) || (load_en && !ld_hit);
    assign if_stall  = !fb_hit;
    mem_bus_arbiter_fetch_buffer #(.W(W)) u_fetch_buffer (
        .clk       (clk),
        .rst       (rst),
        .pc        (pc),
        .fill      (finish && state == MB_IF),
        .fill_tag  (bus_addr),
        .fill_data (rd),
        .inval     (1'b0),
        .hit       (fb_hit),
        .data      (read_inst)
    );
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= MB_IDLE;
            tmo_cnt    <= '0;
            bus_req    <= 1'b0;
            bus_we     <= 1'b0;
            bus_addr   <= '0;
            bus_wdata  <= '0;
            bus_be     <= '0;
            bus_err    <= 1'b0;
            l_data     <= '0;
            load_done  <= 1'b0;
            store_done <= 1'b0;
            ld_addr_q  <= '0;
            st_addr_q  <= '0;
        end else begin
            if (!load_en || l_addr != ld_addr_q) load_done <= 1'b0;
            if (!store_en || s_addr != st_addr_q) store_done <= 1'b0;
            case (state)
                MB_IDLE: begin
                    tmo_cnt <= '0;
                    if (store_en && !st_hit) begin
                        state     <= MB_ST;
                        bus_req   <= 1'b1;
                        bus_we    <= 1'b1;
                        bus_addr  <= s_addr;
                        bus_wdata <= s_data;
                        bus_be    <= s_be;
                        st_addr_q <= s_addr;
                    end else if (load_en && !ld_hit) begin
                        state     <= MB_LD;
                        bus_req   <= 1'b1;
                        bus_we    <= 1'b0;
                        bus_addr  <= l_addr;
                        bus_wdata <= W'(ZERO_WORD);
                        bus_be    <= BE_WORD;
                        ld_addr_q <= l_addr;
                    end else if (!fb_hit) begin
                        state     <= MB_IF;
                        bus_req   <= 1'b1;
                        bus_we    <= 1'b0;
                        bus_addr  <= pc;
                        bus_wdata <= W'(ZERO_WORD);
                        bus_be    <= BE_WORD;
                    end
                end
                default: begin
                    if (finish) begin
                        state   <= MB_IDLE;
                        bus_req <= 1'b0;
                        tmo_cnt <= '0;
                        if (!bus_ack) bus_err <= 1'b1;
                        if (state == MB_ST) store_done <= 1'b1;
                        if (state == MB_LD) begin
                            l_data    <= rd;
                            load_done <= 1'b1;
                        end
                    end else begin
                        tmo_cnt <= tmo_cnt + CW'(1);
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: directed scoreboard bench for the memory bus arbiter
module tb_mem_bus_arbiter;
    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } bus_t;

    logic        clk, rst;
    logic [31:0] pc, read_inst, l_addr, l_data, s_addr, s_data;
    logic [31:0] bus_addr, bus_wdata, bus_rdata;
    logic        load_en, store_en, if_stall, mem_stall;
    logic        bus_req, bus_we, bus_ack, bus_err;
    logic [3:0]  s_be, bus_be;

    bus_t        exp_bus[$];
    logic [31:0] exp_ld[$], exp_if[$], resp_q[$];
    int          passed = 0, total = 0, req_rises = 0;
    int          ack_delay = 1;
    logic        ack_en = 1'b1;

    mem_bus_arbiter #(.W(32), .TIMEOUT(8)) dut (
        .clk(clk), .rst(rst), .pc(pc), .read_inst(read_inst),
        .load_en(load_en), .l_addr(l_addr), .l_data(l_data),
        .store_en(store_en), .s_addr(s_addr), .s_data(s_data), .s_be(s_be),
        .if_stall(if_stall), .mem_stall(mem_stall),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_be(bus_be), .bus_ack(bus_ack),
        .bus_rdata(bus_rdata), .bus_err(bus_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endfunction

    function automatic void push_bus(logic we, logic [31:0] addr, logic [31:0] wdata, logic [3:0] be);
        bus_t e;
        e.we = we; e.addr = addr; e.wdata = wdata; e.be = be;
        exp_bus.push_back(e);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // bus slave: acks ack_delay cycles after the first cycle bus_req is seen high
    initial begin
        int wcnt;
        wcnt = 0;
        bus_ack = 1'b0;
        bus_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            bus_ack = 1'b0;
            if (!bus_req) wcnt = 0;
            else begin
                wcnt++;
                if (ack_en && wcnt == ack_delay + 1) begin
                    bus_ack = 1'b1;
                    bus_rdata = resp_q.size() > 0 ? resp_q.pop_front() : 32'h0;
                end
            end
        end
    end

    // monitor: pops expectations whenever the DUT presents a transaction or result
    initial begin
        logic prev_req, prev_ms, prev_is, hold_bad;
        bus_t held, e, cur;
        prev_req = 1'b0; prev_ms = 1'b0; prev_is = 1'b1; hold_bad = 1'b0; held = '0;
        forever begin
            @(negedge clk);
            cur = {bus_we, bus_addr, bus_wdata, bus_be};
            if (bus_req && !prev_req) begin
                req_rises++;
                if (exp_bus.size() == 0) begin
                    total++;
                    $display("FAIL unexpected_req: got addr %h expected no request", bus_addr);
                end else begin
                    e = exp_bus.pop_front();
                    check("bus_we", 32'(bus_we), 32'(e.we));
                    check("bus_addr", bus_addr, e.addr);
                    check("bus_wdata", bus_wdata, e.wdata);
                    check("bus_be", 32'(bus_be), 32'(e.be));
                end
                held = cur;
                hold_bad = 1'b0;
            end else if (bus_req && cur != held) hold_bad = 1'b1;
            if (!bus_req && prev_req) check("bus_hold", 32'(hold_bad), 32'h0);
            if (!mem_stall && prev_ms) begin
                if (exp_ld.size() == 0) begin
                    total++;
                    $display("FAIL unexpected_mem_done: got l_data %h expected stall", l_data);
                end else check("l_data", l_data, exp_ld.pop_front());
            end
            if (!if_stall && prev_is) begin
                if (exp_if.size() == 0) begin
                    total++;
                    $display("FAIL unexpected_if_done: got read_inst %h expected stall", read_inst);
                end else check("read_inst", read_inst, exp_if.pop_front());
            end
            prev_req = bus_req; prev_ms = mem_stall; prev_is = if_stall;
        end
    end

    initial begin
        int n;
        logic [6:0] rq, ms;
        logic all_hi;
        rst = 1'b0; pc = '0; load_en = 1'b0; l_addr = '0;
        store_en = 1'b0; s_addr = '0; s_data = '0; s_be = 4'hF;
        #2;
        check("rst_bus_req", 32'(bus_req), 32'h0);
        check("rst_bus_outs", {bus_addr | bus_wdata}, 32'h0);
        check("rst_bus_flags", 32'({bus_we, bus_err, bus_be}), 32'h0);
        check("rst_data", read_inst | l_data, 32'h0);
        check("rst_if_stall", 32'(if_stall), 32'h1);

        // fetch miss then hit
        step(); step();
        ack_delay = 1;
        push_bus(1'b0, 32'h0, 32'h0, 4'hF);
        resp_q.push_back(32'h2408_0005);
        exp_if.push_back(32'h2408_0005);
        rst = 1'b1;
        @(negedge clk); check("fetch_c0_req", 32'(bus_req), 32'h0);
        @(negedge clk); check("fetch_c1_req", 32'(bus_req), 32'h1);
        @(negedge clk); check("fetch_c2_stall", 32'(if_stall), 32'h1);
        @(negedge clk); check("fetch_c3_stall", 32'(if_stall), 32'h0);
        check("fetch_c3_inst", read_inst, 32'h2408_0005);
        repeat (5) @(negedge clk);
        check("fetch_hold_no_req", 32'(req_rises), 32'h1);

        // load with four wait cycles
        step();
        ack_delay = 4;
        push_bus(1'b0, 32'h100, 32'h0, 4'hF);
        resp_q.push_back(32'hCAFE_0001);
        exp_ld.push_back(32'hCAFE_0001);
        load_en = 1'b1; l_addr = 32'h100;
        n = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (mem_stall) n++;
        end
        check("load_stall_cycles", 32'(n), 32'd6);
        check("load_data", l_data, 32'hCAFE_0001);
        step(); load_en = 1'b0; repeat (2) step();

        // store and load together: write, idle cycle, read
        ack_delay = 1;
        push_bus(1'b1, 32'h200, 32'h1234_5678, 4'b0011);
        push_bus(1'b0, 32'h204, 32'h0, 4'hF);
        resp_q.push_back(32'h0);
        resp_q.push_back(32'hBEEF_0204);
        exp_ld.push_back(32'hBEEF_0204);
        store_en = 1'b1; s_addr = 32'h200; s_data = 32'h1234_5678; s_be = 4'b0011;
        load_en = 1'b1; l_addr = 32'h204;
        rq = '0; ms = '0;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            rq = {rq[5:0], bus_req};
            ms = {ms[5:0], mem_stall};
        end
        check("st_ld_req_pattern", 32'(rq), 32'h36);
        check("st_ld_stall_pattern", 32'(ms), 32'h7E);
        step(); store_en = 1'b0; load_en = 1'b0; s_be = 4'hF; repeat (2) step();

        // pc changes while a fetch is in flight
        ack_delay = 3;
        push_bus(1'b0, 32'h10, 32'h0, 4'hF);
        push_bus(1'b0, 32'h14, 32'h0, 4'hF);
        resp_q.push_back(32'h1111_0010);
        resp_q.push_back(32'h2222_0014);
        exp_if.push_back(32'h2222_0014);
        pc = 32'h10;
        @(posedge clk); @(posedge clk); #1;
        pc = 32'h14;
        all_hi = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            all_hi = all_hi & if_stall;
        end
        check("pc_change_stall_held", 32'(all_hi), 32'h1);
        @(negedge clk); check("pc_change_stall_drop", 32'(if_stall), 32'h0);
        repeat (2) step();

        // load that is never acked
        ack_en = 1'b0;
        push_bus(1'b0, 32'h300, 32'h0, 4'hF);
        exp_ld.push_back(32'hDEAD_BEEF);
        load_en = 1'b1; l_addr = 32'h300;
        n = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus_req) n++;
        end
        check("tmo_req_cycles", 32'(n), 32'd8);
        check("tmo_err", 32'(bus_err), 32'h1);
        check("tmo_data", l_data, 32'hDEAD_BEEF);
        check("tmo_mem_stall", 32'(mem_stall), 32'h0);
        step(); load_en = 1'b0; ack_en = 1'b1; repeat (3) step();
        check("tmo_err_sticky", 32'(bus_err), 32'h1);

        // asynchronous reset in the middle of a load
        ack_delay = 5;
        push_bus(1'b0, 32'h400, 32'h0, 4'hF);
        exp_ld.push_back(32'h0);
        load_en = 1'b1; l_addr = 32'h400;
        @(posedge clk); @(posedge clk); #2;
        rst = 1'b0; load_en = 1'b0;
        #1;
        check("arst_bus_req", 32'(bus_req), 32'h0);
        check("arst_bus_err", 32'(bus_err), 32'h0);
        check("arst_outs", bus_addr | read_inst | l_data, 32'h0);
        check("arst_be", 32'(bus_be), 32'h0);
        check("arst_if_stall", 32'(if_stall), 32'h1);
        step(); step();
        ack_delay = 1;
        push_bus(1'b0, 32'h14, 32'h0, 4'hF);
        resp_q.push_back(32'h5555_AAAA);
        exp_if.push_back(32'h5555_AAAA);
        rst = 1'b1;
        n = 0;
        while (if_stall && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("refetch_done", 32'(if_stall), 32'h0);
        repeat (3) step();
        check("req_count", 32'(req_rises), 32'd9);
        check("bus_queue_empty", 32'(exp_bus.size()), 32'h0);
        check("result_queues_empty", 32'(exp_ld.size() + exp_if.size()), 32'h0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
